pc_stack_16: RTL

16-bit program counter with an integrated hardware return-address stack. It sits between the datapath's 16-bit logic/ALU stage, which produces jump targets, and the instruction memory address port, which consumes `out`. It supports reset, load (jump), increment, call (push return address and jump) and return (pop). It is the sequential counterpart to the 16-bit combinational gate library.

---
 rtl/pc_stack_16_if.sv | 39 +++
 rtl/pc_stack_16.sv | 104 ++++++++++
 2 files changed

// File: rtl/pc_stack_16_if.sv
// ---------------------------------------------------------------------------
// pc_stack_16_if
// Bundles the operation strobes, the jump target and the program-counter and
// stack-status outputs of pc_stack_16. clk and reset are not part of this
// bundle; they stay plain module ports.
//
//   in        : 16-bit jump/call target            (master -> slave)
//   load      : jump strobe                        (master -> slave)
//   inc       : increment strobe                   (master -> slave)
//   push      : call strobe                        (master -> slave)
//   pop       : return strobe                      (master -> slave)
//   out       : registered program counter         (slave -> master)
//   full      : stack holds DEPTH entries          (slave -> master)
//   empty     : stack holds no entries             (slave -> master)
//   overflow  : sticky, push attempted while full  (slave -> master)
//   underflow : sticky, pop attempted while empty  (slave -> master)
// ---------------------------------------------------------------------------
interface pc_stack_16_if;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        push;
    logic        pop;
    logic [15:0] out;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;

    modport master (
        output in, load, inc, push, pop,
        input  out, full, empty, overflow, underflow
    );

    modport slave (
        input  in, load, inc, push, pop,
        output out, full, empty, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_16.sv
// ---------------------------------------------------------------------------
// pc_stack_16
// 16-bit program counter with a DEPTH-entry hardware return-address stack.
// One operation per rising clk, priority pop > push > load > inc > hold.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears PC, stack pointer and flags
//   bus   : pc_stack_16_if.slave (in/load/inc/push/pop in,
//           out/full/empty/overflow/underflow out)
//
// Parameters:
//   DEPTH : number of return-address entries (power of two, 2..16)
//   SPW   : stack-pointer width, holds 0..DEPTH inclusive
// ---------------------------------------------------------------------------
module pc_stack_16 #(
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    pc_stack_16_if.slave    bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]    out_q, out_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;
    logic [15:0]    stack_q [DEPTH];

    logic           wr_en;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic [15:0]    ret_addr;
    logic           is_full;
    logic           is_empty;

    assign is_full  = (sp_q == SPW'(DEPTH));
    assign is_empty = (sp_q == '0);
    // sp points at the next free slot; the top of stack sits one below it.
    assign wr_idx   = AW'(sp_q);
    assign rd_idx   = AW'(sp_q - SPW'(1));
    // Return address wraps FFFF -> 0000 like the increment path.
    assign ret_addr = out_q + 16'd1;

    always_comb begin
        out_d = out_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        wr_en = 1'b0;
        if (bus.pop) begin
            if (!is_empty) begin
                out_d = stack_q[rd_idx];
                sp_d  = sp_q - SPW'(1);
            end else begin
                udf_d = 1'b1;
            end
        end else if (bus.push) begin
            // The jump happens even when the return address cannot be saved.
            out_d = bus.in;
            if (!is_full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + SPW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (bus.load) begin
            out_d = bus.in;
        end else if (bus.inc) begin
            out_d = out_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 16'h0000;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Stack contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= ret_addr;
        end
    end

    assign bus.out       = out_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;

endmodule
